// File: rtl/simple_pkg.sv
// Shared pipeline constants: datapath widths and major opcodes.
// Imported by the writeback stage and its register file.
package simple_pkg;

    localparam int DATA_W     = 16;
    localparam int NREG       = 8;
    localparam int REG_ADDR_W = 3;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OP_LOAD   = 7'b0000011;
    localparam opcode_t OP_STORE  = 7'b0100011;
    localparam opcode_t OP_OPIMM  = 7'b0010011;
    localparam opcode_t OP_OP     = 7'b0110011;
    localparam opcode_t OP_BRANCH = 7'b1100011;

    function automatic logic is_load(opcode_t op);
        return op == OP_LOAD;
    endfunction

endpackage

// File: rtl/p5_writeback_if.sv
// Register file port bundle: one write port, two read ports.
// The pipeline drives it as master, the storage array is the slave.
interface p5_writeback_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;

    modport master (
        output we, waddr, wdata, raddr1, raddr2,
        input  rdata1, rdata2
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2,
        output rdata1, rdata2
    );
endinterface

// File: rtl/regfile_8x16.sv
// Architectural register storage, asynchronously cleared.
// Reads are combinational; all entries writable.
module regfile_8x16
    import simple_pkg::*;
#(
    parameter int DATA_W = simple_pkg::DATA_W,
    parameter int NREG   = simple_pkg::NREG
) (
    input  logic          clock,
    input  logic          reset_n,
    p5_writeback_if.slave rf
);

    logic [DATA_W-1:0] mem_q [NREG];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (rf.we) begin
            mem_q[rf.waddr] <= rf.wdata;
        end
    end

    assign rf.rdata1 = mem_q[rf.raddr1];
    assign rf.rdata2 = mem_q[rf.raddr2];

endmodule

// File: rtl/p5_writeback.sv
// Writeback stage: result mux, register write, operand bypass,
// and the load scoreboard that drives the load-use interlock.
module p5_writeback
    import simple_pkg::*;
#(
    parameter int DATA_W = simple_pkg::DATA_W,
    parameter int NREG   = simple_pkg::NREG
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  wb_valid,
    input  logic                  wb_reg_write,
    input  logic                  wb_mem_to_reg,
    input  logic [REG_ADDR_W-1:0] wb_reg_addr,
    input  logic [DATA_W-1:0]     wb_mem_data,
    input  logic [DATA_W-1:0]     wb_alu_data,
    input  logic                  ld_issue,
    input  logic [REG_ADDR_W-1:0] ld_addr,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    output logic [DATA_W-1:0]     rs1_data,
    output logic [DATA_W-1:0]     rs2_data,
    output logic                  stall,
    output logic [NREG-1:0]       pending
);

    p5_writeback_if #(.DW(DATA_W), .AW(REG_ADDR_W)) rf_bus ();

    logic              wb_we;
    logic [DATA_W-1:0] wb_data;
    logic              hit1;
    logic              hit2;
    logic              byp1;
    logic              byp2;
    logic [NREG-1:0]   pending_q;
    logic [NREG-1:0]   pending_d;

    assign wb_we   = wb_valid & wb_reg_write;
    assign wb_data = wb_mem_to_reg ? wb_mem_data : wb_alu_data;

    assign rf_bus.we     = wb_we;
    assign rf_bus.waddr  = wb_reg_addr;
    assign rf_bus.wdata  = wb_data;
    assign rf_bus.raddr1 = rs1_addr;
    assign rf_bus.raddr2 = rs2_addr;

    regfile_8x16 #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
        .clock   (clock),
        .reset_n (reset_n),
        .rf      (rf_bus.slave)
    );

    assign hit1 = wb_we & (wb_reg_addr == rs1_addr);
    assign hit2 = wb_we & (wb_reg_addr == rs2_addr);

    // Only a load writeback resolves a pending hazard in the same cycle.
    assign byp1 = hit1 & wb_mem_to_reg;
    assign byp2 = hit2 & wb_mem_to_reg;

    // Outputs forced quiet while reset is held, even if writeback is active.
    assign rs1_data = !reset_n ? '0 : (hit1 ? wb_data : rf_bus.rdata1);
    assign rs2_data = !reset_n ? '0 : (hit2 ? wb_data : rf_bus.rdata2);

    assign stall = reset_n &
        ((rs1_used & pending_q[rs1_addr] & ~byp1) |
         (rs2_used & pending_q[rs2_addr] & ~byp2));

    // Set after clear so a newer load to the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (wb_we && wb_mem_to_reg) begin
            pending_d[wb_reg_addr] = 1'b0;
        end
        if (ld_issue) begin
            pending_d[ld_addr] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: doc/p5_writeback.md
P5_WRITEBACK -- requirements
Module: p5_writeback

Interface
REQ-001 Parameters, SHALL be exactly:
  DATA_W, default 16, register/data width.
  NREG, default 8, architectural register count.
REQ-002 Ports, SHALL be exactly:
  clock  in  1  single clock; all state updates on rising edge.
  reset_n  in  1  reset, asynchronous assert, active-low.
  wb_valid  in  1  memory-stage output valid this cycle.
  wb_reg_write  in  1  registered WriteReg from memory stage.
  wb_mem_to_reg  in  1  1 = load result, 0 = ALU result.
  wb_reg_addr  in  3  registered RegAddress from memory stage.
  wb_mem_data  in  16  registered readOutData from memory stage.
  wb_alu_data  in  16  ALU result carried alongside.
  ld_issue  in  1  load leaving decode this cycle (scoreboard set).
  ld_addr  in  3  destination of issuing load.
  rs1_addr, rs2_addr  in  3 each  decode read addresses.
  rs1_used, rs2_used  in  1 each  decode actually needs that operand.
  rs1_data, rs2_data  out  16 each  operand values, bypassed.
  stall  out  1  load-use interlock to decode/fetch.
  pending  out  8  scoreboard bits, debug visibility.

Function
REQ-003 wb_data SHALL equal wb_mem_data when wb_mem_to_reg=1, else wb_alu_data.
REQ-004 wb_we SHALL be wb_valid & wb_reg_write; no write when either is 0.
REQ-005 On a rising edge with wb_we=1, register[wb_reg_addr] SHALL take wb_data; all 8 registers writable, no hard-wired zero.
REQ-006 rs1_data/rs2_data SHALL be combinational reads of the register file, no added latency.
REQ-007 Bypass: if wb_we=1 and wb_reg_addr equals rsN_addr, rsN_data SHALL be wb_data in the same cycle.
REQ-008 Scoreboard: on edge with ld_issue=1, pending[ld_addr] SHALL be set to 1.
REQ-009 On edge with wb_we=1 and wb_mem_to_reg=1, pending[wb_reg_addr] SHALL be cleared.
REQ-010 Simultaneous set and clear of the same index SHALL leave it set (newer load wins); different indices each take effect.
REQ-011 stall SHALL be (rs1_used & pending[rs1_addr] & !byp1) | (rs2_used & pending[rs2_addr] & !byp2), where bypN = wb_we & wb_mem_to_reg & (wb_reg_addr==rsN_addr).
REQ-012 stall SHALL be combinational from current inputs and pending state; no extra cycle.
REQ-013 ALU writebacks (wb_mem_to_reg=0) SHALL not alter pending.
REQ-014 ld_issue SHALL be honoured regardless of stall; decode gates it.

Reset
REQ-015 reset_n=0 SHALL asynchronously clear all 8 registers to 16'h0000 and pending to 8'h00.
REQ-016 During reset, stall SHALL be 0 and rsN_data SHALL be 0.
REQ-017 A load in flight when reset asserts SHALL be discarded; no write occurs after release until a new wb_we.
REQ-018 Release SHALL be synchronised externally; first active edge SHALL behave as normal operation.

Structure
REQ-019 A shared package simple_pkg SHALL hold DATA_W, NREG, REG_ADDR_W=3 and the opcode constants used by the pipeline.
REQ-020 The 8x16 storage with one write and two read ports SHALL be a sub-module regfile_8x16; scoreboard, mux and bypass stay in p5_writeback.

Verification
REQ-021 Reset, then read r0..r7 with rsN_used=1 -> all rsN_data=0, stall=0, pending=00.
REQ-022 wb_we, ALU path, addr 3, alu 16'h1234; same cycle rs1_addr=3 -> rs1_data=1234 bypassed; next cycle still 1234 from storage.
REQ-023 ld_issue ld_addr=5; next cycle rs2_addr=5, rs2_used=1 -> stall=1, pending=8'h20; load writeback 16'hBEEF addr 5 -> stall=0 that cycle, rs2_data=BEEF, pending=00 after edge.
REQ-024 Same cycle: ld_issue addr 2 and load writeback addr 2 -> pending[2]=1 after edge.
REQ-025 pending[4]=1, rs1_addr=4, rs1_used=0 -> stall=0; ALU writeback to r4 -> pending[4] still 1.
REQ-026 Assert reset_n=0 mid-cycle with pending=8'h81 and r7=16'hFFFF -> pending=00, r7=0 immediately, before the next clock edge.
